// File: rtl/rx_pkg.sv
// rtl/rx_pkg.sv - shared receive-path constants, prescale encoding and 3-way majority vote
package rx_pkg;

    localparam int PRESCALE_8       = 8;
    localparam int PRESCALE_16      = 16;
    localparam int PRESCALE_32      = 32;
    localparam int PRESCALE_DEFAULT = PRESCALE_8;
    localparam int BIT_CNT_WIDTH    = 3;

    typedef enum logic [1:0] {
        PSEL_8  = 2'd0,
        PSEL_16 = 2'd1,
        PSEL_32 = 2'd2
    } prescale_sel_e;

    function automatic logic majority3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/rx_edge_bit_counter.sv
// rtl/rx_edge_bit_counter.sv - per-bit oversampling edge counter, frame bit counter and bit_done
module rx_edge_bit_counter #(
    parameter int PRESCALE_WIDTH = 6,
    parameter int BIT_CNT_WIDTH  = rx_pkg::BIT_CNT_WIDTH
) (
    input  logic                      CLK,
    input  logic                      RST,
    input  logic [PRESCALE_WIDTH-1:0] Prescale,
    input  logic                      edge_count_enable,
    input  logic                      bit_count_enable,
    output logic [PRESCALE_WIDTH-1:0] edge_cnt,
    output logic [PRESCALE_WIDTH-1:0] p_eff,
    output logic [BIT_CNT_WIDTH-1:0]  bit_cnt,
    output logic                      bit_done
);
    import rx_pkg::*;

    prescale_sel_e             prescale_sel;
    logic [PRESCALE_WIDTH-1:0] p_last;

    // Anything other than the three legal ratios falls back to the default ratio.
    always_comb begin
        prescale_sel = PSEL_8;
        if (Prescale == PRESCALE_WIDTH'(PRESCALE_16)) begin
            prescale_sel = PSEL_16;
        end else if (Prescale == PRESCALE_WIDTH'(PRESCALE_32)) begin
            prescale_sel = PSEL_32;
        end
    end

    always_comb begin
        p_eff = PRESCALE_WIDTH'(PRESCALE_DEFAULT);
        case (prescale_sel)
            PSEL_16: p_eff = PRESCALE_WIDTH'(PRESCALE_16);
            PSEL_32: p_eff = PRESCALE_WIDTH'(PRESCALE_32);
            default: p_eff = PRESCALE_WIDTH'(PRESCALE_8);
        endcase
    end

    assign p_last   = p_eff - PRESCALE_WIDTH'(1);
    assign bit_done = edge_count_enable && (edge_cnt == p_last);

    // Wrapping on >= keeps the counter live if Prescale shrinks mid-bit.
    always_ff @(posedge CLK) begin
        if (RST) begin
            edge_cnt <= '0;
        end else if (!edge_count_enable) begin
            edge_cnt <= '0;
        end else if (edge_cnt >= p_last) begin
            edge_cnt <= '0;
        end else begin
            edge_cnt <= edge_cnt + PRESCALE_WIDTH'(1);
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            bit_cnt <= '0;
        end else if (!bit_count_enable) begin
            bit_cnt <= '0;
        end else if (bit_done) begin
            bit_cnt <= bit_cnt + BIT_CNT_WIDTH'(1);
        end
    end

endmodule

// File: rtl/rx_sample_timing.sv
// rtl/rx_sample_timing.sv - mid-bit triple sampler with majority vote; RX_SAMPLE_TIMING_SYNC_EN adds a 2-flop RX_IN synchronizer
module rx_sample_timing #(
    parameter int PRESCALE_WIDTH = 6,
    parameter int BIT_CNT_WIDTH  = rx_pkg::BIT_CNT_WIDTH
) (
    input  logic                      CLK,
    input  logic                      RST,
    input  logic                      RX_IN,
    input  logic [PRESCALE_WIDTH-1:0] Prescale,
    input  logic                      edge_count_enable,
    input  logic                      bit_count_enable,
    input  logic                      data_samp_en,
    output logic [PRESCALE_WIDTH-1:0] edge_cnt,
    output logic [BIT_CNT_WIDTH-1:0]  bit_cnt,
    output logic                      bit_done,
    output logic                      sampled_bit,
    output logic                      sample_valid
);
    import rx_pkg::*;

    logic [PRESCALE_WIDTH-1:0] p_eff;
    logic [PRESCALE_WIDTH-1:0] mid;
    logic                      rx_s;
    logic                      s0;
    logic                      s1;

    rx_edge_bit_counter #(
        .PRESCALE_WIDTH (PRESCALE_WIDTH),
        .BIT_CNT_WIDTH  (BIT_CNT_WIDTH)
    ) u_counter (
        .CLK               (CLK),
        .RST               (RST),
        .Prescale          (Prescale),
        .edge_count_enable (edge_count_enable),
        .bit_count_enable  (bit_count_enable),
        .edge_cnt          (edge_cnt),
        .p_eff             (p_eff),
        .bit_cnt           (bit_cnt),
        .bit_done          (bit_done)
    );

`ifdef RX_SAMPLE_TIMING_SYNC_EN
    logic [1:0] rx_sync;

    always_ff @(posedge CLK) begin
        if (RST) begin
            rx_sync <= 2'b11;
        end else begin
            rx_sync <= {rx_sync[0], RX_IN};
        end
    end

    assign rx_s = rx_sync[1];
`else
    assign rx_s = RX_IN;
`endif

    assign mid = p_eff >> 1;

    // The third vote is the live line on the mid+1 edge, so only the first two samples are held.
    always_ff @(posedge CLK) begin
        if (RST) begin
            s0           <= 1'b1;
            s1           <= 1'b1;
            sampled_bit  <= 1'b1;
            sample_valid <= 1'b0;
        end else if (!data_samp_en) begin
            sample_valid <= 1'b0;
        end else begin
            if (edge_cnt == mid - PRESCALE_WIDTH'(1)) begin
                s0 <= rx_s;
            end
            if (edge_cnt == mid) begin
                s1 <= rx_s;
            end
            if (edge_cnt == mid + PRESCALE_WIDTH'(1)) begin
                sampled_bit  <= majority3(s0, s1, rx_s);
                sample_valid <= 1'b1;
            end else if (bit_done) begin
                sample_valid <= 1'b0;
            end
        end
    end

endmodule
